// File: rtl/rom_loader_pkg.sv
// Shared constants and FSM state type for the Hack boot loader.
package rom_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [3:0] {
        SYNC, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, RUN, ERROR
    } loaderState_t;

    // States where a stalled sender is treated as a broken frame.
    function automatic logic isTimed(input loaderState_t s);
        return s inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
    endfunction

endpackage

// File: rtl/rom_loader_timeout.sv
// Idle-cycle counter: counts enabled cycles since the last clear, saturating at TIMEOUT.
module loader_timeout #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] idleCnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idleCnt <= '0;
        else if (clear)
            idleCnt <= '0;
        else if (enable && (TIMEOUT != 0) && !expired)
            idleCnt <= idleCnt + 1'b1;
    end

    // TIMEOUT == 0 disables the watchdog entirely.
    assign expired = (TIMEOUT != 0) && (idleCnt == CW'(TIMEOUT));

endmodule

// File: rtl/rom_loader.sv
// Receives a framed program image over a byte stream, writes it into instruction ROM,
// verifies the XOR checksum and releases the CPU from reset on success.
module rom_loader #(
    parameter int MAX_WORDS = 32768,
    parameter int ADDR_W    = 16,
    parameter int TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);
    import rom_loader_pkg::*;

    loaderState_t state;
    logic [7:0]   chk;
    logic [7:0]   hiByte;
    logic [15:0]  wordCnt;
    logic [15:0]  hiLo;
    logic         fire;
    logic         idleEnable;
    logic         idleExpired;

    assign fire       = rx_valid && rx_ready;
    assign hiLo       = {hiByte, rx_data};
    assign idleEnable = isTimed(state);

    loader_timeout #(.TIMEOUT(TIMEOUT)) timeoutCnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (fire),
        .enable  (idleEnable),
        .expired (idleExpired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SYNC;
            cpu_reset <= 1'b1;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            rx_ready  <= 1'b1;
            chk       <= '0;
            wordCnt   <= '0;
            hiByte    <= '0;
        end else begin
            rom_we <= 1'b0;
            if (idleEnable && !fire && idleExpired) begin
                state     <= ERROR;
                error     <= 1'b1;
                cpu_reset <= 1'b1;
            end else begin
                case (state)
                    // Idle, running and failed states all restart on a sync byte.
                    SYNC, RUN, ERROR: if (fire && rx_data == SYNC_BYTE) begin
                        state     <= LEN_HI;
                        chk       <= '0;
                        wordCnt   <= '0;
                        rom_addr  <= '0;
                        cpu_reset <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                    end
                    LEN_HI: if (fire) begin
                        hiByte <= rx_data;
                        chk    <= chk ^ rx_data;
                        state  <= LEN_LO;
                    end
                    LEN_LO: if (fire) begin
                        chk     <= chk ^ rx_data;
                        wordCnt <= hiLo;
                        if (32'(hiLo) > 32'(MAX_WORDS)) begin
                            state <= ERROR;
                            error <= 1'b1;
                        end else if (hiLo == 16'd0) begin
                            state <= CHECK;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                    DATA_HI: if (fire) begin
                        hiByte <= rx_data;
                        chk    <= chk ^ rx_data;
                        state  <= DATA_LO;
                    end
                    DATA_LO: if (fire) begin
                        chk       <= chk ^ rx_data;
                        rom_wdata <= hiLo;
                        rom_we    <= 1'b1;
                        rx_ready  <= 1'b0;
                        state     <= WRITE;
                    end
                    WRITE: begin
                        rom_addr <= rom_addr + 1'b1;
                        wordCnt  <= wordCnt - 16'd1;
                        rx_ready <= 1'b1;
                        state    <= (wordCnt == 16'd1) ? CHECK : DATA_HI;
                    end
                    CHECK: if (fire) begin
                        if (rx_data == chk) begin
                            state     <= RUN;
                            cpu_reset <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end

endmodule
